riscv_writeback: RTL and testbench
==================================

// Module: riscv_writeback
// PURPOSE
//  Write-side companion of the register file: arbitrates results from the single-cycle ALU path and
//  the long-latency LSU/muldiv path and drives the regfile write port through a one-entry output
//  register. Holds a 32-entry pending-write scoreboard and raises hazard_out so decode stalls on
//  operands that are not yet architecturally visible. Sits between execute/memory and the regfile.
// PARAMETERS
//  XLEN    32  data width of results and write data
//  NREGS   32  architectural registers (x0 hardwired zero; address width clog2(NREGS)=5)
// PORTS
//  clk_in          in   1     clock; all state on posedge
//  rst_n_in        in   1     asynchronous, active-low reset
//  alu_valid_in    in   1     ALU result valid this cycle (no backpressure; always accepted)
//  alu_rd_in       in   5     ALU destination register
//  alu_data_in     in   XLEN  ALU result
//  lsu_valid_in    in   1     long-path result valid
//  lsu_ready_out   out  1     long-path result accepted when valid&ready
//  lsu_rd_in       in   5     long-path destination register
//  lsu_data_in     in   XLEN  long-path result
//  issue_valid_in  in   1     decode presents an instruction this cycle
//  issue_long_in   in   1     instruction writes rd via the long path
//  issue_rd_in     in   5     instruction destination register
//  ra_in, rb_in    in   5     instruction source registers
//  hazard_out      out  1     decode must stall; issue not recorded
//  wb_we_out       out  1     to regfile write_enable_in
//  wb_rd_out       out  5     to regfile rd_in
//  wb_data_out     out  XLEN  to regfile wd_in
//  idle_out        out  1     no pending long writes and wb_we_out==0 (for fence/halt)
// BEHAVIOUR
//  Reset (async assert, sync deassert upstream): wb_we_out=0, wb_rd_out=0, wb_data_out=0,
//   pending mask=0; lsu_ready_out=0 while rst_n_in=0; idle_out=1 after reset.
//  Arbitration: ALU has strict priority. lsu_ready_out = rst_n_in & ~alu_valid_in (combinational).
//   Winner latched at posedge into wb_*; latency result-in -> wb_we_out = 1 cycle; regfile is written
//   at the following edge. No valid cycle -> wb_we_out=0 next cycle (wb_rd/data hold).
//  rd==0: result accepted (handshake completes) but wb_we_out=0; x0 never marked pending.
//  Scoreboard: pending[r] set at posedge when issue_valid_in & issue_long_in & ~hazard_out & r!=0;
//   cleared at posedge of LSU handshake with lsu_rd_in==r. Same-edge set and clear of same r: set wins.
//  hazard_out = issue_valid_in & (P(ra_in) | P(rb_in) | P(issue_rd_in)), where
//   P(r) = r!=0 & (pending[r] | (wb_we_out & wb_rd_out==r)); rd term prevents WAW overtaking.
//  ALU results are not scoreboarded (execute bypass covers them) except via the wb_rd_out match.
//  LSU result for a non-pending rd: still written; protocol error flagged by bench assertion only.
//  Reset mid-operation: pending and wb state cleared immediately; in-flight long results discarded.
// STRUCTURE
//  riscv_pkg: XLEN, NREGS, REG_ADDR_W=5, typedef reg_addr_t, typedef wb_req_t {we, rd, data}.
//  Sub-module riscv_scoreboard: pending mask, set/clear logic, P(r) lookups; top keeps arbiter + wb reg.
// TESTING
//  ALU x5=0x1234 alone -> next cycle wb_we_out=1, wb_rd_out=5, wb_data_out=0x1234; then wb_we_out=0.
//  ALU x3 and LSU x4 same cycle -> lsu_ready_out=0, x3 written; LSU held; x4=data next cycle after.
//  Issue long x7, then issue with ra=7 -> hazard_out=1 until LSU x7 accepted plus one cycle, then 0.
//  ALU/LSU rd=0 data=0xFFFFFFFF -> handshake completes, wb_we_out stays 0; issue long rd=0 no pending.
//  Same-edge LSU clear of x9 and new long issue to x9 -> pending[9]=1 afterwards, idle_out=0.
//  Assert rst_n_in low with 3 regs pending and wb_we_out=1 -> outputs 0 immediately, idle_out=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared widths and types for the writeback stage and its scoreboard.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int NREGS      = 32;
   localparam int REG_ADDR_W = $clog2(NREGS);

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      logic            we;
      reg_addr_t       rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/riscv_scoreboard.sv
// Pending-write mask for long-latency results plus the busy lookups decode needs.
// A register is busy while a long result is outstanding or while it sits in the
// writeback register and has not yet reached the regfile.
module riscv_scoreboard
   import riscv_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_n_i,
   input  logic      set_en_i,
   input  reg_addr_t set_rd_i,
   input  logic      clr_en_i,
   input  reg_addr_t clr_rd_i,
   input  logic      wb_we_i,
   input  reg_addr_t wb_rd_i,
   input  reg_addr_t ra_i,
   input  reg_addr_t rb_i,
   input  reg_addr_t rd_i,
   output logic      busy_ra_o,
   output logic      busy_rb_o,
   output logic      busy_rd_o,
   output logic      any_pending_o
);

   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;
   logic [NREGS-1:0] set_mask;
   logic [NREGS-1:0] clr_mask;

   // Decode set/clear into one-hot masks; set is applied after clear so a
   // new long issue survives a same-edge completion to the same register.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en_i && (set_rd_i != '0)) set_mask[set_rd_i] = 1'b1;
      if (clr_en_i && (clr_rd_i != '0)) clr_mask[clr_rd_i] = 1'b1;
      pending_d = (pending_q & ~clr_mask) | set_mask;
   end

   // Pending mask register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) pending_q <= '0;
      else          pending_q <= pending_d;
   end

   assign busy_ra_o = (ra_i != '0) && (pending_q[ra_i] || (wb_we_i && (wb_rd_i == ra_i)));
   assign busy_rb_o = (rb_i != '0) && (pending_q[rb_i] || (wb_we_i && (wb_rd_i == rb_i)));
   assign busy_rd_o = (rd_i != '0) && (pending_q[rd_i] || (wb_we_i && (wb_rd_i == rd_i)));

   assign any_pending_o = |pending_q;

endmodule

// File: rtl/riscv_writeback.sv
// Writeback stage: ALU-over-LSU arbiter feeding a one-entry register that drives
// the regfile write port, plus the hazard signal decode stalls on.
module riscv_writeback
   import riscv_pkg::*;
(
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            alu_valid_in,
   input  reg_addr_t       alu_rd_in,
   input  logic [XLEN-1:0] alu_data_in,
   input  logic            lsu_valid_in,
   output logic            lsu_ready_out,
   input  reg_addr_t       lsu_rd_in,
   input  logic [XLEN-1:0] lsu_data_in,
   input  logic            issue_valid_in,
   input  logic            issue_long_in,
   input  reg_addr_t       issue_rd_in,
   input  reg_addr_t       ra_in,
   input  reg_addr_t       rb_in,
   output logic            hazard_out,
   output logic            wb_we_out,
   output reg_addr_t       wb_rd_out,
   output logic [XLEN-1:0] wb_data_out,
   output logic            idle_out
);

   wb_req_t wb_q;
   wb_req_t wb_d;
   logic    lsu_hs;
   logic    busy_ra;
   logic    busy_rb;
   logic    busy_rd;
   logic    any_pending;

   assign lsu_ready_out = rst_n_in & ~alu_valid_in;
   assign lsu_hs        = lsu_valid_in & lsu_ready_out;

   // Pick the winner; x0 results complete their handshake but never write.
   // With no winner, rd/data hold and only the write enable drops.
   always_comb begin
      wb_d    = wb_q;
      wb_d.we = 1'b0;
      if (alu_valid_in) begin
         wb_d.we   = (alu_rd_in != '0);
         wb_d.rd   = alu_rd_in;
         wb_d.data = alu_data_in;
      end else if (lsu_hs) begin
         wb_d.we   = (lsu_rd_in != '0);
         wb_d.rd   = lsu_rd_in;
         wb_d.data = lsu_data_in;
      end
   end

   // Writeback output register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) wb_q <= '0;
      else           wb_q <= wb_d;
   end

   riscv_scoreboard u_sb (
      .clk_i         (clk_in),
      .rst_n_i       (rst_n_in),
      .set_en_i      (issue_valid_in & issue_long_in & ~hazard_out),
      .set_rd_i      (issue_rd_in),
      .clr_en_i      (lsu_hs),
      .clr_rd_i      (lsu_rd_in),
      .wb_we_i       (wb_q.we),
      .wb_rd_i       (wb_q.rd),
      .ra_i          (ra_in),
      .rb_i          (rb_in),
      .rd_i          (issue_rd_in),
      .busy_ra_o     (busy_ra),
      .busy_rb_o     (busy_rb),
      .busy_rd_o     (busy_rd),
      .any_pending_o (any_pending)
   );

   // The rd term keeps a younger write from overtaking an outstanding long one.
   assign hazard_out  = issue_valid_in & (busy_ra | busy_rb | busy_rd);
   assign wb_we_out   = wb_q.we;
   assign wb_rd_out   = wb_q.rd;
   assign wb_data_out = wb_q.data;
   assign idle_out    = ~any_pending & ~wb_q.we;

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed bench for riscv_writeback with hand-computed expectations.
module tb_riscv_writeback;
   import riscv_pkg::*;

   logic            clk_in = 1'b0;
   logic            rst_n_in;
   logic            alu_valid_in;
   reg_addr_t       alu_rd_in;
   logic [XLEN-1:0] alu_data_in;
   logic            lsu_valid_in;
   logic            lsu_ready_out;
   reg_addr_t       lsu_rd_in;
   logic [XLEN-1:0] lsu_data_in;
   logic            issue_valid_in;
   logic            issue_long_in;
   reg_addr_t       issue_rd_in;
   reg_addr_t       ra_in;
   reg_addr_t       rb_in;
   logic            hazard_out;
   logic            wb_we_out;
   reg_addr_t       wb_rd_out;
   logic [XLEN-1:0] wb_data_out;
   logic            idle_out;

   int n_chk  = 0;
   int n_fail = 0;
   logic orphan_ok = 1'b0;

   riscv_writeback dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .alu_valid_in   (alu_valid_in),
      .alu_rd_in      (alu_rd_in),
      .alu_data_in    (alu_data_in),
      .lsu_valid_in   (lsu_valid_in),
      .lsu_ready_out  (lsu_ready_out),
      .lsu_rd_in      (lsu_rd_in),
      .lsu_data_in    (lsu_data_in),
      .issue_valid_in (issue_valid_in),
      .issue_long_in  (issue_long_in),
      .issue_rd_in    (issue_rd_in),
      .ra_in          (ra_in),
      .rb_in          (rb_in),
      .hazard_out     (hazard_out),
      .wb_we_out      (wb_we_out),
      .wb_rd_out      (wb_rd_out),
      .wb_data_out    (wb_data_out),
      .idle_out       (idle_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // An LSU result must target a pending register unless the stimulus
   // deliberately sends an orphan result.
   always @(negedge clk_in) begin
      if (rst_n_in && lsu_valid_in && lsu_ready_out && (lsu_rd_in != '0))
         check_val("lsu_rd_pending", 32'(dut.u_sb.pending_q[lsu_rd_in]), orphan_ok ? 32'd0 : 32'd1);
   end

   initial begin
      rst_n_in = 1'b0;
      alu_valid_in = 1'b0; alu_rd_in = '0; alu_data_in = '0;
      lsu_valid_in = 1'b1; lsu_rd_in = '0; lsu_data_in = '0;
      issue_valid_in = 1'b0; issue_long_in = 1'b0; issue_rd_in = '0; ra_in = '0; rb_in = '0;

      // Reset state
      #3;
      check_val("rst_we",    32'(wb_we_out), 0);
      check_val("rst_rd",    32'(wb_rd_out), 0);
      check_val("rst_data",  wb_data_out, 0);
      check_val("rst_idle",  32'(idle_out), 1);
      check_val("rst_ready", 32'(lsu_ready_out), 0);
      tick(); tick();
      rst_n_in = 1'b1;
      lsu_valid_in = 1'b0;
      #1;
      check_val("ready_out_of_rst", 32'(lsu_ready_out), 1);

      // ALU x5 alone
      alu_valid_in = 1'b1; alu_rd_in = 5'd5; alu_data_in = 32'h0000_1234;
      tick();
      alu_valid_in = 1'b0;
      check_val("alu5_we",   32'(wb_we_out), 1);
      check_val("alu5_rd",   32'(wb_rd_out), 5);
      check_val("alu5_data", wb_data_out, 32'h0000_1234);
      check_val("alu5_idle", 32'(idle_out), 0);
      tick();
      check_val("alu5_we_drop",   32'(wb_we_out), 0);
      check_val("alu5_rd_hold",   32'(wb_rd_out), 5);
      check_val("alu5_data_hold", wb_data_out, 32'h0000_1234);
      check_val("alu5_idle_back", 32'(idle_out), 1);

      // ALU x3 beats LSU x4 (x4 issued long first)
      issue_valid_in = 1'b1; issue_long_in = 1'b1; issue_rd_in = 5'd4; ra_in = 5'd1; rb_in = 5'd2;
      #1;
      check_val("iss4_hazard", 32'(hazard_out), 0);
      tick();
      issue_valid_in = 1'b0; issue_long_in = 1'b0;
      alu_valid_in = 1'b1; alu_rd_in = 5'd3; alu_data_in = 32'h0000_AAAA;
      lsu_valid_in = 1'b1; lsu_rd_in = 5'd4; lsu_data_in = 32'h0000_BBBB;
      #1;
      check_val("arb_ready_low", 32'(lsu_ready_out), 0);
      tick();
      alu_valid_in = 1'b0;
      check_val("arb_alu_we",   32'(wb_we_out), 1);
      check_val("arb_alu_rd",   32'(wb_rd_out), 3);
      check_val("arb_alu_data", wb_data_out, 32'h0000_AAAA);
      #1;
      check_val("arb_ready_high", 32'(lsu_ready_out), 1);
      tick();
      lsu_valid_in = 1'b0;
      check_val("arb_lsu_we",   32'(wb_we_out), 1);
      check_val("arb_lsu_rd",   32'(wb_rd_out), 4);
      check_val("arb_lsu_data", wb_data_out, 32'h0000_BBBB);
      tick();
      check_val("arb_done_we",   32'(wb_we_out), 0);
      check_val("arb_done_idle", 32'(idle_out), 1);

      // RAW hazard on long x7
      issue_valid_in = 1'b1; issue_long_in = 1'b1; issue_rd_in = 5'd7; ra_in = 5'd0; rb_in = 5'd0;
      #1;
      check_val("iss7_hazard", 32'(hazard_out), 0);
      tick();
      issue_long_in = 1'b0; issue_rd_in = 5'd8; ra_in = 5'd7;
      #1;
      check_val("raw7_hz_a", 32'(hazard_out), 1);
      check_val("raw7_idle", 32'(idle_out), 0);
      tick();
      #1;
      check_val("raw7_hz_b", 32'(hazard_out), 1);
      lsu_valid_in = 1'b1; lsu_rd_in = 5'd7; lsu_data_in = 32'h0000_0077;
      #1;
      check_val("raw7_hz_hs",    32'(hazard_out), 1);
      check_val("raw7_ready_hs", 32'(lsu_ready_out), 1);
      tick();
      lsu_valid_in = 1'b0;
      #1;
      check_val("raw7_hz_wb", 32'(hazard_out), 1);
      check_val("raw7_wb_rd", 32'(wb_rd_out), 7);
      tick();
      #1;
      check_val("raw7_hz_clear", 32'(hazard_out), 0);
      issue_valid_in = 1'b0; ra_in = 5'd0; issue_rd_in = 5'd0;

      // x0 results and x0 long issue
      alu_valid_in = 1'b1; alu_rd_in = 5'd0; alu_data_in = 32'hFFFF_FFFF;
      tick();
      alu_valid_in = 1'b0;
      check_val("x0_alu_we", 32'(wb_we_out), 0);
      lsu_valid_in = 1'b1; lsu_rd_in = 5'd0; lsu_data_in = 32'hFFFF_FFFF;
      #1;
      check_val("x0_lsu_ready", 32'(lsu_ready_out), 1);
      tick();
      lsu_valid_in = 1'b0;
      check_val("x0_lsu_we", 32'(wb_we_out), 0);
      issue_valid_in = 1'b1; issue_long_in = 1'b1; issue_rd_in = 5'd0;
      #1;
      check_val("x0_iss_hazard", 32'(hazard_out), 0);
      tick();
      issue_valid_in = 1'b0; issue_long_in = 1'b0;
      check_val("x0_pending", dut.u_sb.pending_q, 0);
      check_val("x0_idle",    32'(idle_out), 1);

      // Same-edge clear and set of x9: set wins
      orphan_ok = 1'b1;
      lsu_valid_in = 1'b1; lsu_rd_in = 5'd9; lsu_data_in = 32'h0000_0099;
      issue_valid_in = 1'b1; issue_long_in = 1'b1; issue_rd_in = 5'd9;
      #1;
      check_val("x9_hazard", 32'(hazard_out), 0);
      tick();
      lsu_valid_in = 1'b0;
      #1;
      orphan_ok = 1'b0;
      check_val("x9_pending", 32'(dut.u_sb.pending_q[9]), 1);
      check_val("x9_idle",    32'(idle_out), 0);
      check_val("x9_wb_rd",   32'(wb_rd_out), 9);

      // Build three pending registers with a write in flight, then reset
      issue_rd_in = 5'd10;
      tick();
      issue_rd_in = 5'd11;
      alu_valid_in = 1'b1; alu_rd_in = 5'd1; alu_data_in = 32'h0000_0011;
      tick();
      issue_valid_in = 1'b0; issue_long_in = 1'b0; alu_valid_in = 1'b0;
      check_val("pre_rst_pending", dut.u_sb.pending_q, 32'h0000_0E00);
      check_val("pre_rst_we",      32'(wb_we_out), 1);
      #1;
      lsu_valid_in = 1'b1; lsu_rd_in = 5'd10;
      issue_valid_in = 1'b1; ra_in = 5'd10;
      rst_n_in = 1'b0;
      #1;
      check_val("mid_rst_we",      32'(wb_we_out), 0);
      check_val("mid_rst_rd",      32'(wb_rd_out), 0);
      check_val("mid_rst_data",    wb_data_out, 0);
      check_val("mid_rst_idle",    32'(idle_out), 1);
      check_val("mid_rst_ready",   32'(lsu_ready_out), 0);
      check_val("mid_rst_hazard",  32'(hazard_out), 0);
      check_val("mid_rst_pending", dut.u_sb.pending_q, 0);
      tick();
      lsu_valid_in = 1'b0; issue_valid_in = 1'b0; ra_in = 5'd0;
      rst_n_in = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
